cernbe_bus_arbiter: RTL and testbench

Two-master arbiter that shares one CERN-BE memory-bus target (a register bank or submap slave using the VMEAddr/VMERdMem/VMEWrMem/VMERdDone/VMEWrDone handshake) between two requesters. Each requester issues single-cycle read or write strobes. The arbiter latches each request and forwards one transaction at a time with round-robin fairness. It returns the matching done pulse and read data to the owning master, and aborts with an error flag if the target never answers.

---
 rtl/cernbe_arb_pkg.sv | 6 +
 rtl/cernbe_arb_req_latch.sv | 35 +++
 rtl/cernbe_bus_arbiter.sv | 110 +++++++++++
 tb/tb_cernbe_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cernbe_arb_pkg.sv
// cernbe_arb_pkg: shared types and constants for the two-master bus arbiter
package cernbe_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} arb_state_t;
  typedef logic mst_idx_t;
  localparam logic [63:0] ERR_RDDATA = '1;
endpackage

// File: rtl/cernbe_arb_req_latch.sv
// cernbe_arb_req_latch: holds one outstanding strobe request for a single master
module cernbe_arb_req_latch #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH:1]   addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr,
  output logic                  pending,
  output logic                  is_write,
  output logic [ADDR_WIDTH:1]   addr_q,
  output logic [DATA_WIDTH-1:0] wdata_q
);
  logic take;
  // a strobe landing in the same cycle as the clear is a fresh request, not a duplicate
  assign take = (rd | wr) & (~pending | clr);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= 1'b0;
      is_write <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      pending <= take | (pending & ~clr);
      if (take) begin
        is_write <= wr;
        addr_q <= addr;
        if (wr) wdata_q <= wdata;
      end
    end
endmodule

// File: rtl/cernbe_bus_arbiter.sv
// cernbe_bus_arbiter: round-robin sharing of one CERN-BE memory-bus target between two masters
module cernbe_bus_arbiter
  import cernbe_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH:1]   m0_VMEAddr_i,
  input  logic [DATA_WIDTH-1:0] m0_VMEWrData_i,
  input  logic                  m0_VMERdMem_i,
  input  logic                  m0_VMEWrMem_i,
  output logic [DATA_WIDTH-1:0] m0_VMERdData_o,
  output logic                  m0_VMERdDone_o,
  output logic                  m0_VMEWrDone_o,
  output logic                  m0_Error_o,
  input  logic [ADDR_WIDTH:1]   m1_VMEAddr_i,
  input  logic [DATA_WIDTH-1:0] m1_VMEWrData_i,
  input  logic                  m1_VMERdMem_i,
  input  logic                  m1_VMEWrMem_i,
  output logic [DATA_WIDTH-1:0] m1_VMERdData_o,
  output logic                  m1_VMERdDone_o,
  output logic                  m1_VMEWrDone_o,
  output logic                  m1_Error_o,
  output logic [ADDR_WIDTH:1]   t_VMEAddr_o,
  output logic [DATA_WIDTH-1:0] t_VMEWrData_o,
  output logic                  t_VMERdMem_o,
  output logic                  t_VMEWrMem_o,
  input  logic [DATA_WIDTH-1:0] t_VMERdData_i,
  input  logic                  t_VMERdDone_i,
  input  logic                  t_VMEWrDone_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t state;
  mst_idx_t gnt, last, sel;
  logic [CW-1:0] cnt;
  logic op_wr, done_hit, tout, fin;
  logic [1:0] pend, is_wr, clr, gnt_oh, rd_done, wr_done, err;
  logic [ADDR_WIDTH:1] addr_q [2];
  logic [DATA_WIDTH-1:0] wdata_q [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  cernbe_arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_req0 (
    .clk(Clk), .rst(Rst), .rd(m0_VMERdMem_i), .wr(m0_VMEWrMem_i), .addr(m0_VMEAddr_i),
    .wdata(m0_VMEWrData_i), .clr(clr[0]), .pending(pend[0]), .is_write(is_wr[0]),
    .addr_q(addr_q[0]), .wdata_q(wdata_q[0])
  );
  cernbe_arb_req_latch #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_req1 (
    .clk(Clk), .rst(Rst), .rd(m1_VMERdMem_i), .wr(m1_VMEWrMem_i), .addr(m1_VMEAddr_i),
    .wdata(m1_VMEWrData_i), .clr(clr[1]), .pending(pend[1]), .is_write(is_wr[1]),
    .addr_q(addr_q[1]), .wdata_q(wdata_q[1])
  );
  always_comb begin
    sel = (pend[0] & pend[1]) ? ~last : pend[1];
    gnt_oh = gnt ? 2'b10 : 2'b01;
    done_hit = (state == ISSUE || state == WAIT) & (op_wr ? t_VMEWrDone_i : t_VMERdDone_i);
    tout = (state == WAIT) & ~done_hit & (cnt == CW'(TIMEOUT));
    fin = done_hit | tout;
    clr = fin ? gnt_oh : 2'b00;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      op_wr <= 1'b0;
      t_VMEAddr_o <= '0;
      t_VMEWrData_o <= '0;
      t_VMERdMem_o <= 1'b0;
      t_VMEWrMem_o <= 1'b0;
      rd_done <= '0;
      wr_done <= '0;
      err <= '0;
      rdata[0] <= '0;
      rdata[1] <= '0;
    end else begin
      t_VMERdMem_o <= 1'b0;
      t_VMEWrMem_o <= 1'b0;
      rd_done <= clr & {2{~op_wr}};
      wr_done <= clr & {2{op_wr}};
      err <= tout ? gnt_oh : 2'b00;
      if (state == IDLE && |pend) begin
        state <= ISSUE;
        gnt <= sel;
        op_wr <= is_wr[sel];
        cnt <= '0;
        t_VMEAddr_o <= addr_q[sel];
        t_VMEWrData_o <= wdata_q[sel];
        t_VMERdMem_o <= ~is_wr[sel];
        t_VMEWrMem_o <= is_wr[sel];
      end else if (fin) begin
        state <= IDLE;
        last <= gnt;
        if (~op_wr) rdata[gnt] <= tout ? ERR_RDDATA[DATA_WIDTH-1:0] : t_VMERdData_i;
      end else if (state != IDLE) begin
        state <= WAIT;
        cnt <= cnt + 1'b1;
      end
    end
  assign m0_VMERdDone_o = rd_done[0];
  assign m1_VMERdDone_o = rd_done[1];
  assign m0_VMEWrDone_o = wr_done[0];
  assign m1_VMEWrDone_o = wr_done[1];
  assign m0_Error_o = err[0];
  assign m1_Error_o = err[1];
  assign m0_VMERdData_o = rdata[0];
  assign m1_VMERdData_o = rdata[1];
endmodule

// File: tb/tb_cernbe_bus_arbiter.sv
// tb_cernbe_bus_arbiter: directed table, corner sequences and random traffic against a transaction-level model
module tb_cernbe_bus_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TO = 255;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  logic [AW:1] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [1:0] m_rd = '0, m_wr = '0;
  logic [DW-1:0] t_rdata = '0;
  logic t_rdd = 1'b0, t_wrd = 1'b0;
  wire [DW-1:0] rdq [2];
  wire [1:0] rdd, wrd, erro;
  wire [AW:1] t_addr;
  wire [DW-1:0] t_wdata;
  wire t_rd, t_wr;
  cernbe_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .m0_VMEAddr_i(m_addr[0]), .m0_VMEWrData_i(m_wdata[0]), .m0_VMERdMem_i(m_rd[0]), .m0_VMEWrMem_i(m_wr[0]),
    .m0_VMERdData_o(rdq[0]), .m0_VMERdDone_o(rdd[0]), .m0_VMEWrDone_o(wrd[0]), .m0_Error_o(erro[0]),
    .m1_VMEAddr_i(m_addr[1]), .m1_VMEWrData_i(m_wdata[1]), .m1_VMERdMem_i(m_rd[1]), .m1_VMEWrMem_i(m_wr[1]),
    .m1_VMERdData_o(rdq[1]), .m1_VMERdDone_o(rdd[1]), .m1_VMEWrDone_o(wrd[1]), .m1_Error_o(erro[1]),
    .t_VMEAddr_o(t_addr), .t_VMEWrData_o(t_wdata), .t_VMERdMem_o(t_rd), .t_VMEWrMem_o(t_wr),
    .t_VMERdData_i(t_rdata), .t_VMERdDone_i(t_rdd), .t_VMEWrDone_i(t_wrd)
  );
  typedef struct packed {logic wr; logic [AW:1] addr; logic [DW-1:0] data;} req_t;
  typedef struct {int m; int kind; logic [AW:1] addr; logic [DW-1:0] wdata; int lat; logic [DW-1:0] rdata; int off; bit exp_wr;} vec_t;
  int checks = 0, failures = 0, cyc = 0;
  bit mpend [2];
  int mvis [2];
  req_t mreq [2];
  bit last = 1'b1;
  int free_at = 0;
  bit busy, tmute, twr;
  int tm, tcnt, icyc;
  bit mute, noise, fixed, force_done;
  int lat_min = 0, lat_max = 2;
  logic [DW-1:0] fixval;
  bit ev, nv, ewr, nwr, eerr, nerr;
  int em, nm;
  logic [DW-1:0] edata, ndata;
  logic [DW-1:0] hold [2];
  int ndone [2];
  int glog [$];
  bit want_v [2], want_rd [2], want_wr [2];
  logic [AW:1] want_addr [2];
  logic [DW-1:0] want_data [2];
  vec_t tbl [5];
  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask
  task automatic req(input int m, input int kind, input logic [AW:1] a, input logic [DW-1:0] d);
    want_v[m] = 1'b1;
    want_rd[m] = (kind != 1);
    want_wr[m] = (kind != 0);
    want_addr[m] = a;
    want_data[m] = d;
  endtask
  // one clock of the model: check outputs, follow target strobes, answer as the target, drive masters
  task automatic step();
    bit [2:0] ea;
    bit c0, c1, es;
    int g;
    @(negedge Clk);
    cyc++;
    for (int m = 0; m < 2; m++) begin
      ea = (ev && em == m) ? {eerr, ewr, ~ewr} : 3'b000;
      chk({erro[m], wrd[m], rdd[m]} == ea, "done_flags", {erro[m], wrd[m], rdd[m]}, ea);
      if (ev && em == m && !ewr) hold[m] = edata;
      chk(rdq[m] == hold[m], "rd_data", rdq[m], hold[m]);
      if (rdd[m] | wrd[m]) ndone[m]++;
    end
    if (ev) begin
      free_at = cyc;
      last = (em == 1);
    end
    c0 = mpend[0] && mvis[0] <= cyc - 1;
    c1 = mpend[1] && mvis[1] <= cyc - 1;
    es = (free_at <= cyc - 1) && (c0 || c1);
    chk((t_rd | t_wr) == es, "tgt_strobe", t_rd | t_wr, es);
    chk(!(t_rd && t_wr), "strobe_excl", {t_rd, t_wr}, 0);
    if (es && (t_rd | t_wr)) begin
      g = (c0 && c1) ? int'(!last) : int'(c1);
      glog.push_back(g);
      chk(t_addr == mreq[g].addr, "tgt_addr", t_addr, mreq[g].addr);
      chk(t_wr == mreq[g].wr, "tgt_type", t_wr, mreq[g].wr);
      if (mreq[g].wr) chk(t_wdata == mreq[g].data, "tgt_wdata", t_wdata, mreq[g].data);
      busy = 1'b1; tm = g; twr = mreq[g].wr; tmute = mute; icyc = cyc;
      tcnt = $urandom_range(lat_max, lat_min);
      free_at = 1 << 30;
    end
    t_rdd = 1'b0;
    t_wrd = 1'b0;
    t_rdata = DW'($urandom);
    nv = 1'b0;
    if (busy && tmute) begin
      if (cyc == icyc + TO) begin
        nv = 1'b1; nm = tm; nwr = twr; nerr = 1'b1; ndata = '1; busy = 1'b0;
      end
    end else if (busy && tcnt == 0) begin
      if (fixed) t_rdata = fixval;
      if (twr) t_wrd = 1'b1; else t_rdd = 1'b1;
      nv = 1'b1; nm = tm; nwr = twr; nerr = 1'b0; ndata = t_rdata; busy = 1'b0;
    end else if (busy) begin
      tcnt--;
      if (noise && $urandom_range(3, 0) == 0) begin
        if (twr) t_rdd = 1'b1; else t_wrd = 1'b1;
      end
    end else if (noise && $urandom_range(3, 0) == 0) begin
      t_rdd = 1'($urandom_range(1, 0));
      t_wrd = !t_rdd;
    end
    if (force_done) begin
      t_rdd = 1'b1; t_wrd = 1'b1; force_done = 1'b0;
    end
    if (nv) mpend[nm] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_rd[m] = 1'b0;
      m_wr[m] = 1'b0;
      m_addr[m] = AW'($urandom);
      m_wdata[m] = DW'($urandom);
      if (want_v[m]) begin
        m_rd[m] = want_rd[m];
        m_wr[m] = want_wr[m];
        m_addr[m] = want_addr[m];
        m_wdata[m] = want_data[m];
        if (!mpend[m]) begin
          mpend[m] = 1'b1;
          mvis[m] = cyc + 1;
          mreq[m] = '{wr: want_wr[m], addr: want_addr[m], data: want_data[m]};
        end
        want_v[m] = 1'b0;
      end
    end
    ev = nv; em = nm; ewr = nwr; eerr = nerr; edata = ndata;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic chk_quiet(input string name);
    chk({t_rd, t_wr, rdd, wrd, erro} == 0, {name, "_strobes"}, {t_rd, t_wr, rdd, wrd, erro}, 0);
    chk(t_addr == 0 && t_wdata == 0, {name, "_tgt_bus"}, {t_addr, t_wdata}, 0);
    chk(rdq[0] == 0 && rdq[1] == 0, {name, "_rdata"}, {rdq[1], rdq[0]}, 0);
  endtask
  task automatic do_reset();
    #2 Rst = 1'b1;
    #1 chk_quiet("async_reset");
    m_rd = '0; m_wr = '0; t_rdd = 1'b0; t_wrd = 1'b0;
    @(negedge Clk);
    cyc++;
    Rst = 1'b0;
    mpend = '{1'b0, 1'b0}; last = 1'b1; busy = 1'b0; ev = 1'b0; nv = 1'b0;
    hold = '{16'h0, 16'h0}; want_v = '{1'b0, 1'b0}; free_at = cyc;
  endtask
  initial begin
    int b0, b1, ord, found, got_wr;
    logic [DW-1:0] got_data;
    bit seen_err;
    logic [DW-1:0] err_data;
    tbl[0] = '{0, 0, 20'h00004, 16'h0000, 1, 16'hA5A5, 4, 1'b0};
    tbl[1] = '{1, 1, 20'h12345, 16'hBEEF, 0, 16'h0000, 3, 1'b1};
    tbl[2] = '{1, 0, 20'hFFFFF, 16'h0000, 3, 16'h5A5A, 6, 1'b0};
    tbl[3] = '{0, 1, 20'h00000, 16'h1234, 2, 16'h0000, 5, 1'b1};
    tbl[4] = '{0, 2, 20'h00007, 16'h7777, 0, 16'h0000, 3, 1'b1};
    m_addr = '{20'h0, 20'h0};
    m_wdata = '{16'h0, 16'h0};
    hold = '{16'h0, 16'h0};
    repeat (3) @(negedge Clk);
    chk_quiet("reset_value");
    Rst = 1'b0;
    b0 = ndone[0]; b1 = ndone[1];
    req(0, 1, 20'h00010, 16'h1234);
    req(1, 1, 20'h00020, 16'h5678);
    run(14);
    ord = glog.size() >= 2 ? glog[0] * 2 + glog[1] : -1;
    chk(glog.size() == 2, "tie_grant_count", glog.size(), 2);
    chk(ord == 1, "tie_order_m0_first", ord, 1);
    chk(ndone[0] - b0 == 1 && ndone[1] - b1 == 1, "tie_one_done_each", {ndone[1] - b1, ndone[0] - b0}, 'h100000001);
    fixed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run(4);
      lat_min = tbl[i].lat;
      lat_max = tbl[i].lat;
      fixval = tbl[i].rdata;
      req(tbl[i].m, tbl[i].kind, tbl[i].addr, tbl[i].wdata);
      step();
      found = 0; got_wr = 0; got_data = '0;
      for (int k = 1; k <= 10; k++) begin
        step();
        if (found == 0 && (rdd[tbl[i].m] | wrd[tbl[i].m])) begin
          found = k; got_wr = wrd[tbl[i].m]; got_data = rdq[tbl[i].m];
        end
      end
      chk(found == tbl[i].off, "vec_latency", found, tbl[i].off);
      chk(got_wr == int'(tbl[i].exp_wr), "vec_type", got_wr, tbl[i].exp_wr);
      if (!tbl[i].exp_wr) chk(got_data == tbl[i].rdata, "vec_rdata", got_data, tbl[i].rdata);
    end
    fixed = 1'b0;
    lat_min = 0; lat_max = 3;
    glog.delete();
    for (int i = 0; i < 60; i++) begin
      req(0, $urandom_range(2, 0), AW'($urandom), DW'($urandom));
      req(1, $urandom_range(2, 0), AW'($urandom), DW'($urandom));
      step();
    end
    run(20);
    chk(glog.size() >= 8, "alt_grant_count", glog.size(), 8);
    for (int i = 1; i < 8 && i < glog.size(); i++)
      chk(glog[i] != glog[i - 1], "alt_grant", glog[i], !glog[i - 1]);
    noise = 1'b1; lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      for (int m = 0; m < 2; m++)
        if ($urandom_range(2, 0) == 0) req(m, $urandom_range(2, 0), AW'($urandom), DW'($urandom));
      step();
    end
    noise = 1'b0;
    run(20);
    b0 = ndone[0];
    mute = 1'b1;
    req(1, 0, 20'h00033, 16'h0);
    run(3);
    mute = 1'b0;
    req(0, 1, 20'h00044, 16'hCAFE);
    seen_err = 1'b0; err_data = '0;
    for (int i = 0; i < TO + 20; i++) begin
      step();
      if (rdd[1] && erro[1]) begin seen_err = 1'b1; err_data = rdq[1]; end
    end
    chk(seen_err, "timeout_error", seen_err, 1);
    chk(err_data == 16'hFFFF, "timeout_rdata", err_data, 16'hFFFF);
    chk(ndone[0] - b0 == 1, "after_timeout_m0", ndone[0] - b0, 1);
    mute = 1'b1;
    req(1, 0, 20'h00055, 16'h0);
    run(10);
    do_reset();
    mute = 1'b0;
    force_done = 1'b1;
    b0 = ndone[0]; b1 = ndone[1];
    run(5);
    chk(ndone[0] == b0 && ndone[1] == b1, "late_done_ignored", ndone[0] + ndone[1], b0 + b1);
    lat_min = 1; lat_max = 1;
    req(1, 0, 20'h00066, 16'h0);
    run(10);
    chk(ndone[1] - b1 == 1, "post_reset_txn", ndone[1] - b1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
